// File: rtl/flash_sample_sequencer.sv
// flash_sample_sequencer: walks flash word addresses, fetches each 32-bit word and plays it out as two samples.
module flash_sample_sequencer #(
   parameter int                ADDR_W   = 23,
   parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF,
   parameter int                SAMPLE_W = 16
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  sample_tick,
   input  logic                  play,
   input  logic                  direction,
   input  logic                  restart,
   output logic                  read_start,
   input  logic                  read_done,
   input  logic [2*SAMPLE_W-1:0] flash_data,
   output logic [ADDR_W-1:0]     flash_addr,
   output logic [SAMPLE_W-1:0]   audio_sample,
   output logic                  sample_valid,
   output logic                  underrun
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND, ADVANCE} state_t;
   state_t                state, state_n;
   logic [ADDR_W-1:0]     addr_n, reload;
   logic [SAMPLE_W-1:0]   sample_n, lo, hi;
   logic [2*SAMPLE_W-1:0] buf_q, buf_n;
   logic                  valid_n, und_n, pend, pend_n, rev, rev_n;
   assign read_start = state == REQ;
   assign lo = buf_q[SAMPLE_W-1:0];
   assign hi = buf_q[2*SAMPLE_W-1:SAMPLE_W];
   assign reload = direction ? MAX_ADDR : '0;
   always_comb begin
      state_n = state;
      addr_n = flash_addr;
      sample_n = audio_sample;
      valid_n = 1'b0;
      und_n = underrun;
      buf_n = buf_q;
      pend_n = pend;
      rev_n = rev;
      if (sample_tick && play && (state == REQ || state == WAIT_DATA || state == ADVANCE))
         und_n = 1'b1;
      case (state)
         IDLE:
            if (restart) begin
               addr_n = reload;
               state_n = play ? REQ : IDLE;
            end else if (play)
               state_n = REQ;
         REQ: begin
            state_n = WAIT_DATA;
            if (restart)
               pend_n = 1'b1;
         end
         WAIT_DATA:
            // a read in flight always completes; a pending restart only decides what happens to its word
            if (read_done) begin
               if (restart || pend) begin
                  pend_n = 1'b0;
                  addr_n = reload;
                  state_n = play ? REQ : IDLE;
               end else begin
                  buf_n = flash_data;
                  rev_n = direction;
                  state_n = OUT_FIRST;
               end
            end else if (restart)
               pend_n = 1'b1;
         OUT_FIRST, OUT_SECOND:
            if (restart) begin
               addr_n = reload;
               state_n = play ? REQ : IDLE;
            end else if (sample_tick && play) begin
               sample_n = ((state == OUT_FIRST) ^ rev) ? lo : hi;
               valid_n = 1'b1;
               state_n = state == OUT_FIRST ? OUT_SECOND : ADVANCE;
            end
         ADVANCE:
            if (restart) begin
               addr_n = reload;
               state_n = play ? REQ : IDLE;
            end else begin
               addr_n = direction ? (flash_addr == '0 ? MAX_ADDR : flash_addr - ADDR_W'(1))
                                  : (flash_addr == MAX_ADDR ? '0 : flash_addr + ADDR_W'(1));
               state_n = REQ;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge reset)
      if (reset) begin
         state <= IDLE;
         flash_addr <= '0;
         audio_sample <= '0;
         sample_valid <= 1'b0;
         underrun <= 1'b0;
         buf_q <= '0;
         pend <= 1'b0;
         rev <= 1'b0;
      end else begin
         state <= state_n;
         flash_addr <= addr_n;
         audio_sample <= sample_n;
         sample_valid <= valid_n;
         underrun <= und_n;
         buf_q <= buf_n;
         pend <= pend_n;
         rev <= rev_n;
      end
endmodule

// File: tb/tb_flash_sample_sequencer.sv
// tb_flash_sample_sequencer: directed and randomized playback against a playback-level model with decoupled scoreboard.
module tb_flash_sample_sequencer;
   localparam logic [22:0] MAX = 23'h7FFFF;
   logic        CLK = 0, reset = 0, sample_tick = 0, play = 0, direction = 0, restart = 0, read_done = 0;
   logic [31:0] flash_data = '0;
   logic        read_start, sample_valid, underrun;
   logic [22:0] flash_addr;
   logic [15:0] audio_sample;
   flash_sample_sequencer dut (
      .CLK(CLK), .reset(reset), .sample_tick(sample_tick), .play(play), .direction(direction),
      .restart(restart), .read_start(read_start), .read_done(read_done), .flash_data(flash_data),
      .flash_addr(flash_addr), .audio_sample(audio_sample), .sample_valid(sample_valid), .underrun(underrun));
   always #10 CLK = ~CLK;
   typedef struct { logic [22:0] addr; int due; } rd_t;
   typedef struct { logic [15:0] s; int due; } smp_t;
   rd_t  rq[$];
   smp_t sq[$];
   rd_t  r;
   smp_t s;
   int   cyc = 0, n_cmp = 0, n_bad = 0;
   always @(posedge CLK) cyc <= cyc + 1;
   // playback model: position, samples still held from the last word, fetch in flight, pending step
   logic [22:0] m_addr;
   logic [15:0] half [2];
   logic [15:0] m_last;
   bit          m_idle, stepping, discard, exp_rd, exp_sv;
   int          avail, req_at, und_at;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic reset_model();
      m_addr = '0;
      m_idle = 1;
      stepping = 0;
      discard = 0;
      avail = 0;
      req_at = -1;
      und_at = 32'h7FFF_FFFF;
      m_last = '0;
      rq.delete();
      sq.delete();
   endtask
   always @(negedge CLK) if (!reset) begin
      exp_rd = rq.size() > 0 && rq[0].due == cyc;
      check("read_start", 32'(read_start), 32'(exp_rd));
      if (exp_rd) begin
         r = rq.pop_front();
         check("read_addr", 32'(flash_addr), 32'(r.addr));
      end
      exp_sv = sq.size() > 0 && sq[0].due == cyc;
      check("sample_valid", 32'(sample_valid), 32'(exp_sv));
      if (exp_sv) begin
         s = sq.pop_front();
         m_last = s.s;
      end
      check("audio_sample", 32'(audio_sample), 32'(m_last));
      check("underrun", 32'(underrun), 32'(und_at < cyc));
   end
   function automatic void go(input logic [22:0] a, input bit pl, input int c);
      m_addr = a;
      m_idle = !pl;
      if (pl) begin
         req_at = c + 1;
         rq.push_back('{a, c + 1});
      end
   endfunction
   task automatic step(input bit tk, input bit pl, input bit rs, input bit dn, input bit dr, input logic [31:0] d);
      int          c = cyc;
      bit          infl = req_at >= 0 && c >= req_at;
      logic [22:0] reload = dr ? MAX : 23'd0;
      sample_tick = tk;
      play = pl;
      restart = rs;
      read_done = dn;
      direction = dr;
      flash_data = d;
      if (tk && pl && (infl || stepping) && und_at > c) und_at = c;
      if (infl) begin
         if (dn && c > req_at) begin
            req_at = -1;
            if (discard || rs) begin
               discard = 0;
               go(reload, pl, c);
            end else begin
               half[0] = dr ? d[31:16] : d[15:0];
               half[1] = dr ? d[15:0] : d[31:16];
               avail = 2;
            end
         end else if (rs) discard = 1;
      end else if (rs) begin
         avail = 0;
         stepping = 0;
         go(reload, pl, c);
      end else if (stepping) begin
         stepping = 0;
         go(dr ? (m_addr == 0 ? MAX : m_addr - 23'd1) : (m_addr == MAX ? 23'd0 : m_addr + 23'd1), 1, c);
      end else if (m_idle) begin
         if (pl) go(m_addr, 1, c);
      end else if (avail > 0 && tk && pl) begin
         sq.push_back('{half[2 - avail], c + 1});
         avail--;
         if (avail == 0) stepping = 1;
      end
      @(posedge CLK);
      #1;
   endtask
   task automatic idle(input int n, input bit pl, input bit dr);
      repeat (n) step(0, pl, 0, 0, dr, 0);
   endtask
   task automatic wait_fetch(input bit dr);
      int k = 0;
      while (!(req_at >= 0 && cyc > req_at) && k < 20) begin
         step(0, 1, 0, 0, dr, 0);
         k++;
      end
      if (k == 20) begin
         n_cmp++;
         n_bad++;
         $display("FAIL fetch_timeout: no read in flight after %0d cycles", k);
      end
   endtask
   task automatic serve(input logic [31:0] d, input bit dr);
      wait_fetch(dr);
      step(0, 1, 0, 1, dr, d);
   endtask
   task automatic word(input logic [31:0] d, input bit dr);
      serve(d, dr);
      step(1, 1, 0, 0, dr, 0);
      step(1, 1, 0, 0, dr, 0);
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_read_start"}, 32'(read_start), 0);
      check({tag, "_flash_addr"}, 32'(flash_addr), 0);
      check({tag, "_audio_sample"}, 32'(audio_sample), 0);
      check({tag, "_sample_valid"}, 32'(sample_valid), 0);
      check({tag, "_underrun"}, 32'(underrun), 0);
   endtask
   task automatic do_reset(input string tag);
      #3 reset = 1;
      #1 check_zero(tag);
      reset_model();
      {sample_tick, play, direction, restart, read_done} = '0;
      @(posedge CLK);
      #1 reset = 0;
   endtask
   bit pl, dr, tk, rs, dn, wild;
   initial begin
      reset_model();
      #2 reset = 1;
      #3 check_zero("por");
      repeat (2) @(posedge CLK);
      #1 reset = 0;
      // basic forward playback
      idle(2, 0, 0);
      word(32'hBBBB_AAAA, 0);
      step(0, 1, 0, 0, 0, 0);
      check("t1_second_sample", 32'(audio_sample), 32'h0000_BBBB);
      // restart toward the end, forward wrap, reverse wrap and order
      wait_fetch(0);
      step(0, 1, 1, 0, 1, 0);
      serve(32'h0, 1);
      word(32'h1111_2222, 0);
      idle(1, 1, 0);
      serve(32'h1234_5678, 1);
      step(1, 1, 0, 0, 1, 0);
      check("t2_rev_first", 32'(audio_sample), 32'h0000_1234);
      step(1, 1, 0, 0, 1, 0);
      check("t2_rev_second", 32'(audio_sample), 32'h0000_5678);
      wait_fetch(1);
      check("t2_rev_wrap", 32'(flash_addr), 32'(MAX));
      // pause in the second half
      serve(32'hCAFE_0001, 0);
      step(1, 1, 0, 0, 0, 0);
      repeat (5) step(1, 0, 0, 0, 0, 0);
      check("t3_paused_sample", 32'(audio_sample), 32'h0000_0001);
      check("t3_paused_underrun", 32'(underrun), 0);
      step(1, 1, 0, 0, 0, 0);
      check("t3_resumed", 32'(audio_sample), 32'h0000_CAFE);
      // underrun is sticky until reset
      wait_fetch(0);
      step(1, 1, 0, 0, 0, 0);
      check("t4_underrun_set", 32'(underrun), 1);
      word($urandom, 0);
      check("t4_underrun_sticky", 32'(underrun), 1);
      do_reset("t4_rst");
      // restart during a fetch at address 5
      for (int i = 0; i < 5; i++) word($urandom, 0);
      wait_fetch(0);
      check("t5_addr", 32'(flash_addr), 5);
      step(0, 1, 1, 0, 0, 0);
      idle(3, 1, 0);
      serve($urandom, 0);
      check("t5_reread_start", 32'(read_start), 1);
      check("t5_reread_addr", 32'(flash_addr), 0);
      // reset mid-read, stale read_done ignored
      wait_fetch(0);
      do_reset("t6_rst");
      step(0, 0, 0, 1, 0, $urandom);
      idle(5, 0, 0);
      check("t6_idle_addr", 32'(flash_addr), 0);
      // randomized: first without starving ticks, then fully wild
      for (int ph = 0; ph < 2; ph++) begin
         wild = ph == 1;
         pl = 1;
         dr = 0;
         do_reset(wild ? "rnd2_rst" : "rnd1_rst");
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(9) == 0) pl = !pl;
            if ($urandom_range(39) == 0) dr = !dr;
            rs = $urandom_range(59) == 0;
            tk = $urandom_range(3) == 0 && (wild || avail > 0 || m_idle);
            dn = (req_at >= 0 && cyc > req_at) ? $urandom_range(2) == 0 : $urandom_range(49) == 0;
            step(tk, pl, rs, dn, dr, $urandom);
         end
         idle(3, pl, dr);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
